// File: rtl/fb_pkg.sv
// Shared defaults for the frame-buffer compositor, the palette and the bike drawer.
package fb_pkg;

  localparam int PIX_W = 4;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  localparam logic [PIX_W-1:0] TRANSP_IDX = 4'hF;
  localparam logic [PIX_W-1:0] EMPTY_IDX  = 4'h0;

  typedef logic [PIX_W-1:0] color_idx_t;

endpackage

// File: rtl/fb_ram.sv
// Dual-port frame RAM: one write port, one registered read port (read-before-write).
module fb_ram #(
  parameter int ADDR_W = 18,
  parameter int WORD_W = 16,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [WORD_W-1:0] wrData_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [WORD_W-1:0] rdData_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdData_q;

  // Write and read share the edge; the read sees the word as it was before this write.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
    rdData_q <= mem_q[rdAddr_i];
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/fb_compositor.sv
// Frame-buffer compositor: raster read of packed background indices, N prioritised
// sprite layers with a transparent key, active-area blanking and per-frame collision flags.
module fb_compositor #(
  parameter int H_RES        = fb_pkg::H_RES,
  parameter int V_RES        = fb_pkg::V_RES,
  parameter int PIX_W        = fb_pkg::PIX_W,
  parameter int WORD_W       = 16,
  parameter int PIX_PER_WORD = 2,
  parameter int N_LAYERS     = 2,
  parameter logic [PIX_W-1:0] TRANSP_IDX = fb_pkg::TRANSP_IDX,
  parameter logic [PIX_W-1:0] EMPTY_IDX  = fb_pkg::EMPTY_IDX,
  parameter int ADDR_W       = $clog2(H_RES*V_RES/PIX_PER_WORD)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_clk,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  input  logic [N_LAYERS*PIX_W-1:0] layer_pix,
  input  logic                      WE,
  input  logic [ADDR_W-1:0]         write_address,
  input  logic [WORD_W-1:0]         Data_In,
  output logic [PIX_W-1:0]          color_enum,
  output logic                      pix_valid,
  output logic [N_LAYERS-1:0]       collision,
  output logic                      collision_stb
);

  import fb_pkg::*;

  localparam int SLOT   = WORD_W / PIX_PER_WORD;
  localparam int SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int AW1    = ADDR_W + 1;
  localparam int DEPTH  = H_RES * V_RES / PIX_PER_WORD;
  localparam int LW     = N_LAYERS * PIX_W;

  // Stage 0 combinational address/slot decode
  logic              inArea;
  logic [AW1-1:0]    linAddr;
  logic [ADDR_W-1:0] rdAddr_d;
  logic [SLOT_W-1:0] slot_d;

  // Pipeline registers
  logic              active0_q, active1_q;
  logic [ADDR_W-1:0] rdAddr_q;
  logic [SLOT_W-1:0] slot0_q, slot1_q;
  logic [LW-1:0]     layer0_q, layer1_q;

  // Stage 2 combinational compose/collision
  logic [WORD_W-1:0]   ramData;
  logic [PIX_W-1:0]    bg;
  logic [PIX_W-1:0]    color_d;
  logic [N_LAYERS-1:0] opaque;
  logic [N_LAYERS-1:0] others;
  logic [N_LAYERS-1:0] hits;
  logic                found;

  // Output and frame bookkeeping registers
  logic [PIX_W-1:0]    color_q;
  logic                valid_q;
  logic [N_LAYERS-1:0] hitAcc_q;
  logic [N_LAYERS-1:0] collision_q;
  logic                stb_q;
  logic                frameClkPrev_q;
  logic                frameEdge;

  // Padding bits between packed slots never reach the output
  logic unusedRamBits;
  assign unusedRamBits = ^ramData;

  // Raster position to word address and slot; widened by one bit so the product never wraps
  always_comb begin
    inArea   = (int'(DrawX) < H_RES) && (int'(DrawY) < V_RES);
    linAddr  = AW1'(DrawY) * AW1'(H_RES) + AW1'(DrawX);
    rdAddr_d = ADDR_W'(linAddr / AW1'(PIX_PER_WORD));
    slot_d   = SLOT_W'(DrawX % 10'(PIX_PER_WORD));
  end

  // Stage 0: capture pixel request; address holds while outside the active area
  always_ff @(posedge Clk) begin
    if (Reset) begin
      active0_q <= 1'b0;
      rdAddr_q  <= '0;
      slot0_q   <= '0;
      layer0_q  <= '0;
    end else begin
      active0_q <= inArea;
      slot0_q   <= slot_d;
      layer0_q  <= layer_pix;
      if (inArea) begin
        rdAddr_q <= rdAddr_d;
      end
    end
  end

  fb_ram #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i    (Clk),
    .we_i     (WE),
    .wrAddr_i (write_address),
    .wrData_i (Data_In),
    .rdAddr_i (rdAddr_q),
    .rdData_o (ramData)
  );

  // Stage 1: delay sideband to line up with the RAM read data
  always_ff @(posedge Clk) begin
    if (Reset) begin
      active1_q <= 1'b0;
      slot1_q   <= '0;
      layer1_q  <= '0;
    end else begin
      active1_q <= active0_q;
      slot1_q   <= slot0_q;
      layer1_q  <= layer0_q;
    end
  end

  // Pick background slot, resolve layer priority and detect per-layer hits
  always_comb begin
    bg = EMPTY_IDX;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      if (slot1_q == SLOT_W'(k)) begin
        bg = ramData[k*SLOT +: PIX_W];
      end
    end

    opaque = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      opaque[i] = (layer1_q[i*PIX_W +: PIX_W] != TRANSP_IDX);
    end

    color_d = bg;
    found   = 1'b0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (!found && opaque[i]) begin
        color_d = layer1_q[i*PIX_W +: PIX_W];
        found   = 1'b1;
      end
    end
    if (!active1_q) begin
      color_d = EMPTY_IDX;
    end

    hits   = '0;
    others = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      others  = opaque & ~(N_LAYERS'(1) << i);
      hits[i] = active1_q && opaque[i] && ((bg != EMPTY_IDX) || (|others));
    end
  end

  // Stage 2: registered pixel output
  always_ff @(posedge Clk) begin
    if (Reset) begin
      color_q <= EMPTY_IDX;
      valid_q <= 1'b0;
    end else begin
      color_q <= color_d;
      valid_q <= active1_q;
    end
  end

  assign frameEdge = frame_clk & ~frameClkPrev_q;

  // Accumulate hits over a frame; publish on the frame_clk rise including that cycle's hits
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frameClkPrev_q <= 1'b0;
      hitAcc_q       <= '0;
      collision_q    <= '0;
      stb_q          <= 1'b0;
    end else begin
      frameClkPrev_q <= frame_clk;
      stb_q          <= frameEdge;
      if (frameEdge) begin
        collision_q <= hitAcc_q | hits;
        hitAcc_q    <= '0;
      end else begin
        hitAcc_q    <= hitAcc_q | hits;
      end
    end
  end

  assign color_enum    = color_q;
  assign pix_valid     = valid_q;
  assign collision     = collision_q;
  assign collision_stb = stb_q;

endmodule

// File: doc/fb_compositor.md
# fb_compositor

Parametrised successor to the game's frame-buffer/bike combiner. Reads packed colour indices from an internal dual-port frame RAM in raster order, overlays N sprite (bike) layers with a transparent key, and emits one colour index per pixel to the palette/VGA stage. Adds what the single-layer combiner lacked: a pipelined, latency-aligned read path, per-layer priority, blanking outside the active area, and per-frame trail-collision flags for the game FSM.

## Interface
Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines
- PIX_W, 4, bits per colour index
- WORD_W, 16, RAM word width
- PIX_PER_WORD, 2, pixels packed per word; slot k occupies bits [k*SLOT+PIX_W-1 : k*SLOT], where SLOT = WORD_W/PIX_PER_WORD
- N_LAYERS, 2, sprite layers; layer 0 has highest priority
- TRANSP_IDX, 4'hF, sprite index meaning "no sprite here"
- EMPTY_IDX, 4'h0, background index meaning "no trail"
- ADDR_W, derived: $clog2(H_RES*V_RES/PIX_PER_WORD)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  frame strobe (~60 Hz), sampled in the Clk domain
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- layer_pix  in  N_LAYERS*PIX_W  sprite indices for (DrawX,DrawY); layer i at [i*PIX_W +: PIX_W]
- WE  in  1  frame-RAM write enable
- write_address  in  ADDR_W  word address
- Data_In  in  WORD_W  word to write
- color_enum  out  PIX_W  composed index
- pix_valid  out  1  color_enum belongs to the active area
- collision  out  N_LAYERS  previous frame's hit flags, bit i = layer i
- collision_stb  out  1  one-cycle pulse when collision updates

## Operation
- Stage 0 (input register): if DrawX<H_RES and DrawY<V_RES, read_address = (DrawY*H_RES + DrawX)/PIX_PER_WORD, slot = DrawX mod PIX_PER_WORD, active=1; else active=0 and read_address held. layer_pix, slot and active are registered.
- Stage 1: RAM read, one-cycle latency; layer_pix/slot/active delayed one more cycle to align.
- Stage 2 (output register): bg = selected slot of data_Out. Result = first layer i (ascending) with pix != TRANSP_IDX, else bg. If !active: color_enum = EMPTY_IDX, pix_valid = 0.
- Collision: in stage 2, for active pixels, layer i hits when its pix != TRANSP_IDX and (bg != EMPTY_IDX or any other layer j != i is also opaque). Hits OR into hit_acc[i].
- Frame boundary: rising edge of frame_clk (registered previous value vs. current). On the edge cycle: collision <= hit_acc | this cycle's hits; hit_acc <= 0; collision_stb = 1. collision holds until the next edge.
- RAM: true dual-port, one write port (WE/write_address/Data_In), one read port. Same-address read and write in one cycle returns the old word (read-before-write).
- Address arithmetic is unsigned and carried at ADDR_W+1 bits before truncation; no wrap inside the active area.

## Timing
- Latency 3 Clk cycles from DrawX/DrawY/layer_pix to color_enum/pix_valid; throughput one pixel per cycle, no stalls.
- Reset (synchronous, applied at the next Clk edge): color_enum = EMPTY_IDX, pix_valid = 0, collision = 0, collision_stb = 0, hit_acc = 0, pipeline active bits = 0, frame_clk history = 0. RAM contents are not cleared.
- Reset mid-frame discards in-flight pixels; the first valid output appears 3 cycles after Reset deasserts.
- frame_clk held high for many cycles produces one collision_stb only.

## Structure
- Package fb_pkg: PIX_W, TRANSP_IDX, EMPTY_IDX, H_RES, V_RES defaults, and a colour-index typedef shared with the palette and the bike drawer.
- One sub-module: fb_ram (parametrised dual-port, ADDR_W x WORD_W, registered read). Compositor and collision logic stay in fb_compositor.

## Test plan
- Write 0x0302 at address 0, sweep X=0,1 at Y=0, all layers 0xF -> color_enum 0x2 then 0x3, pix_valid=1, exactly 3 cycles after each input.
- Address 1, layer0=0x5, layer1=0x6 at X=2 -> 0x5; layer0=0xF -> 0x6; both 0xF -> background slot.
- X=640 or Y=480 -> color_enum=0x0, pix_valid=0, hit_acc unchanged even with opaque layers.
- Layer 1 opaque over background 0x4 in frame N, frame_clk rises -> collision=2'b10 with one-cycle collision_stb; next frame clean -> collision=2'b00.
- Both layers opaque on EMPTY background, same pixel -> collision=2'b11 at next edge; hit on the edge cycle itself lands in that published value.
- Reset asserted mid-line with pending hits -> all outputs zero next cycle; next frame_clk edge reports collision=0.
